pc_fetch_ctrl: RTL

//  Program-counter register and instruction-fetch controller, directly downstream of the PC select mux.
//  - Latches the mux output (pc_next) as the architectural PC.
//  - Issues one instruction-memory read at a time and returns the fetched instruction to decode.
//  - Decode interface is a one-entry valid/ready buffer.
//  - Kills in-flight fetches on a redirect (branch/jump taken).

---
 rtl/cpu_pkg.sv | 19 +
 rtl/pc_reg.sv | 35 +++
 rtl/pc_fetch_ctrl.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared types and constants for the instruction-fetch front end.
//   fetch_state_t        : fetch controller states (request / wait)
//   RESET_VECTOR_DEFAULT : default PC value loaded on reset
//   INSTR_NOP            : instruction word placed in the buffer when no
//                          real instruction was fetched (misaligned trap)
// ---------------------------------------------------------------------------
package cpu_pkg;

  typedef enum logic {
    S_REQ,
    S_WAIT
  } fetch_state_t;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_NOP            = 32'h0000_0000;

endpackage

// File: rtl/pc_reg.sv
// ---------------------------------------------------------------------------
// pc_reg
// Architectural program-counter register with load enable.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset, loads RESET_VECTOR
//   i_load : capture i_d on the next rising edge
//   i_d    : next PC value
//   o_q    : current PC
// ---------------------------------------------------------------------------
module pc_reg #(
  parameter int           N            = 32,
  parameter logic [N-1:0] RESET_VECTOR = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [N-1:0] i_d,
  output logic [N-1:0] o_q
);

  logic [N-1:0] r_q;

  // PC only moves when a fetch is accepted or the flow is redirected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= RESET_VECTOR;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// Program-counter register and single-outstanding instruction-fetch
// controller. Latches the PC select mux output, issues one instruction
// memory read at a time and hands the fetched word to decode through a
// one-entry valid/ready buffer. A redirect kills any fetch in flight.
//
// Optional feature macro: PCFETCH_MISALIGN_TRAP_EN
//   defined   : a fetch from a PC with pc[1:0]!=0 is not sent to memory;
//               the buffer instead receives a misalign marker entry and
//               fetch halts until the next redirect.
//   undefined : if_misalign is tied low, misaligned addresses are issued.
//
// Ports:
//   clk, rst        : clock (rising edge), async active-high reset
//   pc_next         : next PC from the PC select mux
//   redirect        : taken branch/jump, pc_next holds the target
//   stall           : hazard freeze, no new fetch is issued
//   pc              : current PC
//   imem_req_valid  : fetch request valid        imem_req_ready : accepted
//   imem_addr       : fetch address
//   imem_rsp_valid  : read data valid pulse      imem_rsp_data  : instruction
//   if_valid        : buffer holds an entry      if_ready       : decode takes it
//   if_pc, if_instr : buffered PC and instruction
//   if_misalign     : buffered PC was misaligned
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int           n            = 32,
  parameter int           IW           = 32,
  parameter logic [n-1:0] RESET_VECTOR = n'(RESET_VECTOR_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [n-1:0]  pc_next,
  input  logic          redirect,
  input  logic          stall,
  output logic [n-1:0]  pc,
  output logic          imem_req_valid,
  input  logic          imem_req_ready,
  output logic [n-1:0]  imem_addr,
  input  logic          imem_rsp_valid,
  input  logic [IW-1:0] imem_rsp_data,
  output logic          if_valid,
  input  logic          if_ready,
  output logic [n-1:0]  if_pc,
  output logic [IW-1:0] if_instr,
  output logic          if_misalign
);

  fetch_state_t  r_state;
  fetch_state_t  w_nextState;
  logic          r_kill;
  logic [n-1:0]  r_reqPc;
  logic          r_ifValid;
  logic [n-1:0]  r_ifPc;
  logic [IW-1:0] r_ifInstr;

  logic [n-1:0]  w_pc;
  logic          w_canIssue;
  logic          w_reqValid;
  logic          w_reqFire;
  logic          w_rspSeen;
  logic          w_rspLoad;
  logic          w_trapFire;

`ifdef PCFETCH_MISALIGN_TRAP_EN
  logic          r_halt;
  logic          r_ifMisalign;
`endif

  pc_reg #(
    .N            (n),
    .RESET_VECTOR (RESET_VECTOR)
  ) u_pc_reg (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_reqFire || redirect),
    .i_d    (pc_next),
    .o_q    (w_pc)
  );

  // A new fetch may only go out when the buffer is guaranteed to have room
  // for its response, so the single entry can never overflow
  assign w_canIssue = !redirect && !stall && (!r_ifValid || if_ready);

  // Any response observed while waiting ends the fetch; it only lands in
  // the buffer if it was not killed and is not being redirected over
  assign w_rspSeen = (r_state == S_WAIT) && imem_rsp_valid;
  assign w_rspLoad = w_rspSeen && !r_kill && !redirect;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_REQ;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state and request generation
  always_comb begin
    w_nextState = r_state;
    w_reqValid  = 1'b0;
    w_trapFire  = 1'b0;
    case (r_state)
      S_REQ: begin
`ifdef PCFETCH_MISALIGN_TRAP_EN
        if (w_canIssue && !r_halt) begin
          if (w_pc[1:0] != 2'b00) begin
            w_trapFire = 1'b1;
          end else begin
            w_reqValid = 1'b1;
          end
        end
`else
        w_reqValid = w_canIssue;
`endif
        if (w_reqValid && imem_req_ready) begin
          w_nextState = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          w_nextState = S_REQ;
        end
      end
      default: begin
        w_nextState = S_REQ;
      end
    endcase
  end

  // Holding the request low during reset keeps the memory quiet until the
  // first cycle after reset is released
  assign imem_req_valid = w_reqValid && !rst;
  assign imem_addr      = w_pc;
  assign w_reqFire      = imem_req_valid && imem_req_ready;

  // Remember which PC the outstanding fetch belongs to, since the PC
  // register has already moved on by the time the data returns
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reqPc <= '0;
    end else if (w_reqFire) begin
      r_reqPc <= w_pc;
    end
  end

  // Kill marks an in-flight fetch made stale by a redirect. If the response
  // arrives in the redirect cycle it is dropped directly and no kill is
  // needed; a pending kill is consumed by the next response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_kill <= 1'b0;
    end else if (redirect) begin
      r_kill <= (r_state == S_WAIT) && !imem_rsp_valid;
    end else if (w_rspSeen) begin
      r_kill <= 1'b0;
    end
  end

  // Decode buffer: redirect flushes, a load beats a simultaneous drain
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ifValid <= 1'b0;
      r_ifPc    <= '0;
      r_ifInstr <= IW'(INSTR_NOP);
    end else if (redirect) begin
      r_ifValid <= 1'b0;
    end else if (w_rspLoad) begin
      r_ifValid <= 1'b1;
      r_ifPc    <= r_reqPc;
      r_ifInstr <= imem_rsp_data;
    end else if (w_trapFire) begin
      r_ifValid <= 1'b1;
      r_ifPc    <= w_pc;
      r_ifInstr <= IW'(INSTR_NOP);
    end else if (r_ifValid && if_ready) begin
      r_ifValid <= 1'b0;
    end
  end

`ifdef PCFETCH_MISALIGN_TRAP_EN
  // After a misalign marker is produced, fetch stays parked until software
  // control flow moves the PC somewhere else via redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_halt       <= 1'b0;
      r_ifMisalign <= 1'b0;
    end else if (redirect) begin
      r_halt       <= 1'b0;
      r_ifMisalign <= 1'b0;
    end else if (w_rspLoad) begin
      r_ifMisalign <= 1'b0;
    end else if (w_trapFire) begin
      r_halt       <= 1'b1;
      r_ifMisalign <= 1'b1;
    end
  end

  assign if_misalign = r_ifMisalign;
`else
  assign if_misalign = 1'b0;
`endif

  assign pc       = w_pc;
  assign if_valid = r_ifValid;
  assign if_pc    = r_ifPc;
  assign if_instr = r_ifInstr;

endmodule
